// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default constants for the FIFO write arbiter slice.
package fifo_arb_pkg;

   localparam int DEF_N_REQ     = 4;
   localparam int DEF_WIDTH     = 8;
   localparam int DEF_MAX_BURST = 4;

   // Arbiter FSM: IDLE spends one cycle choosing, GRANT streams one burst.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // Requester index following cur, wrapping n-1 back to 0.
   function automatic int wrap_inc(input int cur, input int n);
      return (cur + 1 >= n) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side handshake bundle of the write arbiter.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH
);

   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0][WIDTH-1:0] req_data;
   logic [N_REQ-1:0]            req_ready;
   logic                        fifo_full;
   logic                        fifo_push;
   logic [WIDTH-1:0]            fifo_wdata;
   logic [ID_W-1:0]             grant_id;
   logic                        busy;

   // Arbiter side.
   modport master (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_push, fifo_wdata, grant_id, busy
   );

   // Requesters plus downstream FIFO side.
   modport slave (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_push, fifo_wdata, grant_id, busy
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [ID_W-1:0]  rr_ptr,
   output logic [ID_W-1:0]  index,
   output logic             any_valid
);

   localparam int SUM_W = ID_W + 1;

   logic [2*N_REQ-1:0] dbl_s;
   logic [N_REQ-1:0]   rot_s;
   logic [ID_W-1:0]    off_s;
   logic [SUM_W-1:0]   sum_s;

   // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate the index back.
   always_comb begin
      dbl_s = {valid, valid};
      rot_s = N_REQ'(dbl_s >> rr_ptr);
      off_s = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot_s[k]) begin
            off_s = ID_W'(k);
         end else begin
            off_s = off_s;
         end
      end
      sum_s = {1'b0, rr_ptr} + {1'b0, off_s};
      if (sum_s >= SUM_W'(N_REQ)) begin
         sum_s = sum_s - SUM_W'(N_REQ);
      end else begin
         sum_s = sum_s;
      end
      index     = sum_s[ID_W-1:0];
      any_valid = |valid;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N requesters share one downstream FIFO in bursts.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = DEF_N_REQ,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic              clk,
   input  logic              rst_n,
   fifo_wr_arbiter_if.master bus
);

   localparam int ID_W   = $clog2(N_REQ);
   localparam int BEAT_W = $clog2(MAX_BURST + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST);

   arb_state_e        state_r;
   logic [ID_W-1:0]   rr_ptr_r;
   logic [ID_W-1:0]   grant_id_r;
   logic [BEAT_W-1:0] beat_cnt_r;
   logic              busy_r;

   logic [ID_W-1:0]   pick_idx_s;
   logic              pick_any_s;
   logic              grant_valid_s;
   logic              xfer_s;
   logic [BEAT_W-1:0] beat_nxt_s;
   logic [ID_W-1:0]   ptr_nxt_s;
   logic [N_REQ-1:0]  ready_s;
   logic [WIDTH-1:0]  wdata_s;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_pick (
      .valid     (bus.req_valid),
      .rr_ptr    (rr_ptr_r),
      .index     (pick_idx_s),
      .any_valid (pick_any_s)
   );

   // Data path and handshake: only the grant owner may push, and only when the FIFO has room.
   always_comb begin
      grant_valid_s = bus.req_valid[grant_id_r];
      xfer_s        = 1'b0;
      ready_s       = '0;
      wdata_s       = '0;
      if (state_r == ST_GRANT) begin
         xfer_s              = grant_valid_s & ~bus.fifo_full;
         ready_s[grant_id_r] = xfer_s;
         wdata_s             = bus.req_data[grant_id_r];
      end else begin
         xfer_s  = 1'b0;
         ready_s = '0;
         wdata_s = '0;
      end
      beat_nxt_s = beat_cnt_r + BEAT_W'(1);
      ptr_nxt_s  = ID_W'(wrap_inc(int'(grant_id_r), N_REQ));
   end

   assign bus.req_ready  = ready_s;
   assign bus.fifo_push  = xfer_s;
   assign bus.fifo_wdata = wdata_s;
   assign bus.grant_id   = grant_id_r;
   assign bus.busy       = busy_r;

   // Arbitration FSM: choose in IDLE, stream up to MAX_BURST beats in GRANT, then advance rr_ptr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         rr_ptr_r   <= '0;
         grant_id_r <= '0;
         beat_cnt_r <= '0;
         busy_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pick_any_s) begin
                  state_r    <= ST_GRANT;
                  grant_id_r <= pick_idx_s;
                  beat_cnt_r <= '0;
                  busy_r     <= 1'b1;
               end else begin
                  grant_id_r <= '0;
                  busy_r     <= 1'b0;
               end
            end
            ST_GRANT: begin
               if (!grant_valid_s || (xfer_s && (beat_nxt_s == LAST_BEAT))) begin
                  // Burst finished or owner went quiet: hand the pointer to the next requester.
                  state_r    <= ST_IDLE;
                  rr_ptr_r   <= ptr_nxt_s;
                  grant_id_r <= '0;
                  busy_r     <= 1'b0;
                  if (xfer_s) begin
                     beat_cnt_r <= beat_nxt_s;
                  end else begin
                     beat_cnt_r <= beat_cnt_r;
                  end
               end else if (xfer_s) begin
                  beat_cnt_r <= beat_nxt_s;
               end else begin
                  beat_cnt_r <= beat_cnt_r;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               rr_ptr_r   <= '0;
               grant_id_r <= '0;
               beat_cnt_r <= '0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a transaction-level model.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;
   localparam int DW = N * W;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

   fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_cmp;
   int   n_err;

   // Model: owner of the current grant (-1 = idle), beats moved, round-robin pointer.
   int   m_owner;
   int   m_beats;
   int   m_ptr;

   // Observations of the DUT used by the directed checks.
   int   obs_pushes;
   int   obs_grants[$];
   int   obs_beats[$];
   logic prev_busy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic vbit(input logic [N-1:0] v, input int idx);
      logic [N-1:0] s;
      s = v >> idx;
      return s[0];
   endfunction

   task automatic model_reset();
      m_owner   = -1;
      m_beats   = 0;
      m_ptr     = 0;
      prev_busy = 1'b0;
   endtask

   task automatic clear_obs();
      obs_pushes = 0;
      obs_grants.delete();
      obs_beats.delete();
   endtask

   // One clock cycle: drive at negedge, check combinational and registered outputs, advance model.
   task automatic step(input logic [N-1:0] v, input logic full);
      logic [DW-1:0] data;
      logic          exp_push;
      logic [N-1:0]  exp_ready;
      logic [W-1:0]  exp_wdata;
      int            exp_gid;
      logic          exp_busy;
      @(negedge clk);
      data          = DW'({$urandom, $urandom});
      bus.req_valid = v;
      bus.fifo_full = full;
      bus.req_data  = data;
      #1;
      exp_ready = '0;
      if (m_owner < 0) begin
         exp_push  = 1'b0;
         exp_wdata = '0;
         exp_gid   = 0;
         exp_busy  = 1'b0;
      end else begin
         exp_busy  = 1'b1;
         exp_gid   = m_owner;
         exp_push  = vbit(v, m_owner) && !full;
         exp_wdata = W'(data >> (m_owner * W));
         if (exp_push) begin
            exp_ready = {{(N-1){1'b0}}, 1'b1} << m_owner;
         end
      end
      check("push",  32'(bus.fifo_push),  32'(exp_push));
      check("ready", 32'(bus.req_ready),  32'(exp_ready));
      check("wdata", 32'(bus.fifo_wdata), 32'(exp_wdata));
      check("gid",   32'(bus.grant_id),   32'(exp_gid));
      check("busy",  32'(bus.busy),       32'(exp_busy));
      if (bus.busy && !prev_busy) begin
         obs_grants.push_back(int'(bus.grant_id));
         obs_beats.push_back(0);
      end
      if (bus.fifo_push) begin
         obs_pushes++;
         if (obs_beats.size() > 0) begin
            obs_beats[obs_beats.size()-1] = obs_beats[obs_beats.size()-1] + 1;
         end
      end
      prev_busy = bus.busy;
      if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (m_owner < 0 && vbit(v, c)) begin
               m_owner = c;
               m_beats = 0;
            end
         end
      end else if (!vbit(v, m_owner)) begin
         m_ptr   = (m_owner + 1) % N;
         m_owner = -1;
      end else if (exp_push) begin
         m_beats++;
         if (m_beats == MB) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end
      end
   endtask

   // Assert reset asynchronously, check outputs drop at once, release at the next negedge.
   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "_push"},  32'(bus.fifo_push), 32'd0);
      check({tag, "_busy"},  32'(bus.busy),      32'd0);
      check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
      check({tag, "_gid"},   32'(bus.grant_id),  32'd0);
      model_reset();
      clear_obs();
      bus.req_valid = '0;
      bus.fifo_full = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] rv;
      logic         rf;
      n_cmp         = 0;
      n_err         = 0;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.fifo_full = 1'b0;
      bus.req_data  = '0;
      model_reset();
      clear_obs();
      repeat (3) @(negedge clk);
      apply_reset("por");

      // Single requester 0: one idle cycle, four pushes, then rr_ptr has moved to 1.
      apply_reset("r31");
      repeat (5) step(4'b0001, 1'b0);
      check("s31_pushes", 32'(obs_pushes), 32'd4);
      step(4'b0011, 1'b0);
      check("s31_idle", 32'(bus.busy), 32'd0);
      step(4'b0011, 1'b0);
      check("s31_ngrants", 32'(obs_grants.size()), 32'd2);
      if (obs_grants.size() >= 2) begin
         check("s31_g0", 32'(obs_grants[0]), 32'd0);
         check("s31_next", 32'(obs_grants[1]), 32'd1);
      end

      // All requesting: order 0,1,2,3,0 with four beats each.
      apply_reset("r32");
      repeat (25) step(4'b1111, 1'b0);
      check("s32_ngrants", 32'(obs_grants.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < obs_grants.size()) begin
            check("s32_order", 32'(obs_grants[i]), 32'(i % N));
            check("s32_beats", 32'(obs_beats[i]), 32'(MB));
         end
      end

      // Requester 2 stalled by a full FIFO after beat 1.
      apply_reset("r33");
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b0);
      repeat (3) begin
         step(4'b0100, 1'b1);
         check("s33_stall_push",  32'(bus.fifo_push), 32'd0);
         check("s33_stall_ready", 32'(bus.req_ready), 32'd0);
         check("s33_stall_busy",  32'(bus.busy),      32'd1);
      end
      repeat (3) step(4'b0100, 1'b0);
      check("s33_pushes", 32'(obs_pushes), 32'd4);
      step(4'b0000, 1'b0);
      check("s33_done", 32'(bus.busy), 32'd0);
      if (obs_grants.size() >= 1) begin
         check("s33_gid", 32'(obs_grants[0]), 32'd2);
      end

      // Requester 1 drops valid after two beats; the pointer moves to 2.
      apply_reset("r34");
      repeat (3) step(4'b0010, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0110, 1'b0);
      check("s34_exit",   32'(bus.busy),    32'd0);
      check("s34_pushes", 32'(obs_pushes),  32'd2);
      step(4'b0110, 1'b0);
      check("s34_next", 32'(bus.grant_id), 32'd2);

      // Reset during beat 3; after release arbitration restarts at requester 0.
      apply_reset("r35a");
      repeat (4) step(4'b1111, 1'b0);
      check("s35_beat3", 32'(bus.fifo_push), 32'd1);
      apply_reset("r35b");
      repeat (2) step(4'b1111, 1'b0);
      check("s35_ngrants", 32'(obs_grants.size()), 32'd1);
      if (obs_grants.size() >= 1) begin
         check("s35_restart", 32'(obs_grants[0]), 32'd0);
      end

      // Only requester 3 from rr_ptr 0, then the pointer wraps back to 0.
      apply_reset("r36");
      repeat (5) step(4'b1000, 1'b0);
      step(4'b1001, 1'b0);
      step(4'b1001, 1'b0);
      check("s36_ngrants", 32'(obs_grants.size()), 32'd2);
      if (obs_grants.size() >= 2) begin
         check("s36_g3",   32'(obs_grants[0]), 32'd3);
         check("s36_wrap", 32'(obs_grants[1]), 32'd0);
      end

      // Random traffic against the model.
      apply_reset("rnd");
      rv = '0;
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            rv = N'($urandom_range(0, (1 << N) - 1));
         end
         rf = ($urandom_range(0, 3) == 0);
         step(rv, rf);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the data word width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, giving the maximum beats per grant (1..15).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  N_REQ  per-requester word available.
REQ-007 req_data  in  N_REQ x WIDTH  per-requester write data.
REQ-008 req_ready  out  N_REQ  per-requester word accepted this cycle.
REQ-009 fifo_full  in  1  full flag of the downstream shared FIFO.
REQ-010 fifo_push  out  1  write strobe to the shared FIFO.
REQ-011 fifo_wdata  out  WIDTH  write data to the shared FIFO.
REQ-012 grant_id  out  clog2(N_REQ)  index of the current grant owner; 0 when idle.
REQ-013 busy  out  1  high while in GRANT.

Function
REQ-014 The FSM SHALL have two states: IDLE and GRANT.
REQ-015 In IDLE with any req_valid high, the block SHALL select the first valid requester at or after rr_ptr (wrapping N_REQ-1 -> 0), latch it as grant_id, clear beat_cnt and enter GRANT next cycle.
REQ-016 In IDLE, req_ready and fifo_push SHALL be 0 (one-cycle arbitration latency).
REQ-017 In GRANT, fifo_push and req_ready[grant_id] SHALL both equal req_valid[grant_id] AND NOT fifo_full, combinationally; all other req_ready bits SHALL be 0.
REQ-018 fifo_wdata SHALL equal req_data[grant_id] in GRANT and 0 in IDLE.
REQ-019 Each transfer (fifo_push high) SHALL increment beat_cnt by 1; beat_cnt width is clog2(MAX_BURST+1).
REQ-020 GRANT SHALL exit to IDLE when a transfer makes beat_cnt equal MAX_BURST, or when req_valid[grant_id] is low.
REQ-021 On GRANT exit, rr_ptr SHALL become grant_id+1, wrapping N_REQ-1 -> 0.
REQ-022 fifo_full high in GRANT SHALL stall without transfer; the grant is held and beat_cnt is unchanged.
REQ-023 Simultaneous valid requesters SHALL be served in round-robin order; no requester waits more than N_REQ grants.
REQ-024 busy SHALL be 1 exactly when the state is GRANT.

Reset
REQ-025 Asserting rst_n low SHALL immediately force state IDLE, rr_ptr 0, grant_id 0, beat_cnt 0, busy 0, fifo_push 0, and req_ready all 0.
REQ-026 Reset asserted mid-burst SHALL drop the grant; no partial-burst state SHALL persist after release.
REQ-027 The first arbitration after reset release SHALL start from requester 0.

Structure
REQ-028 The FSM state enum SHALL reside in the shared package fifo_arb_pkg.
REQ-029 The package SHALL also hold the default constants for N_REQ and MAX_BURST.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: valid vector, rr_ptr; outputs: index, any_valid).

Verification
REQ-031 Reset release, req_valid=4'b0001, fifo_full=0 -> one idle cycle, then 4 consecutive pushes from requester 0, exit to IDLE, rr_ptr=1.
REQ-032 req_valid=4'b1111 held, fifo_full=0 -> grant order 0,1,2,3,0, each grant exactly 4 beats.
REQ-033 Requester 2 granted, fifo_full high for 3 cycles after beat 1 -> no push and req_ready=0 during the stall, then beats 2-4 complete, beat_cnt reaches 4.
REQ-034 Requester 1 drops req_valid after 2 beats -> GRANT exits next edge, rr_ptr=2, only 2 words pushed.
REQ-035 rst_n asserted during beat 3 of a burst -> fifo_push=0 and busy=0 immediately; after release, grant starts at requester 0.
REQ-036 req_valid=4'b1000 with rr_ptr=0 -> grant_id=3; after the burst, rr_ptr wraps to 0.
